// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter for the shared data-memory port
//
// Purpose:
//   Shares one data-memory port among four requesters (MEM stage, debug
//   read-back, debug write, memory initialisation). Issues a registered
//   one-hot grant, drives the 2-bit operand mux select for the owner and
//   revokes any grant held for MAX_HOLD consecutive cycles.
//
// Parameters:
//   MAX_HOLD  maximum consecutive grant cycles for one owner (2..256)
//   NB_CNT    hold counter width, derived from MAX_HOLD
//
// Ports:
//   clock_i    system clock, rising edge
//   reset_i    asynchronous active-high reset
//   enable_i   allows new grants from IDLE; no effect on a running grant
//   req_i      level request per requester
//   release_i  end-of-use strobe; only the owner's bit is honoured
//   grant_o    one-hot registered grant, zero when there is no owner
//   sel_o      mux select = owner index; keeps last owner's index when idle
//   busy_o     high while a grant is active
//   timeout_o  one-cycle pulse when the hold limit revokes a grant

module mem_port_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int NB_CNT   = $clog2(MAX_HOLD)
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       enable_i,
  input  logic [3:0] req_i,
  input  logic [3:0] release_i,
  output logic [3:0] grant_o,
  output logic [1:0] sel_o,
  output logic       busy_o,
  output logic       timeout_o
);

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } state_t;

  // Counter value seen on the last cycle an owner may keep the grant.
  localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(MAX_HOLD - 1);

  state_t            state_q, state_d;
  logic [3:0]        grant_q, grant_d;
  logic [1:0]        sel_q, sel_d;
  logic              busy_q, busy_d;
  logic              timeout_q, timeout_d;
  logic [1:0]        last_q, last_d;
  logic [NB_CNT-1:0] cnt_q, cnt_d;

  logic              win_found;
  logic [1:0]        win_idx;
  logic [1:0]        cand;
  logic              owner_done;

  // Round-robin search: last+1, last+2, last+3, then last itself. The 2-bit
  // addition wraps, so k=4 lands back on last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_q;
    cand      = '0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!win_found && req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // While GRANTED, sel_q is the owner index, so it picks the owner's bits.
  assign owner_done = release_i[sel_q] || !req_i[sel_q];

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    last_d    = last_q;
    cnt_d     = cnt_q;

    case (state_q)
      IDLE: begin
        grant_d = 4'b0000;
        busy_d  = 1'b0;
        if (enable_i && win_found) begin
          state_d = GRANTED;
          grant_d = 4'b0001 << win_idx;
          sel_d   = win_idx;
          busy_d  = 1'b1;
          last_d  = win_idx;
          cnt_d   = '0;
        end
      end

      GRANTED: begin
        if (owner_done || cnt_q == CNT_LAST) begin
          // A release on the limit cycle wins over the timeout.
          state_d   = IDLE;
          grant_d   = 4'b0000;
          busy_d    = 1'b0;
          cnt_d     = '0;
          timeout_d = !owner_done;
        end else begin
          cnt_d = cnt_q + NB_CNT'(1);
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      grant_q   <= 4'b0000;
      sel_q     <= 2'd0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      last_q    <= 2'd3;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
    end
  end

  assign grant_o   = grant_q;
  assign sel_o     = sel_q;
  assign busy_o    = busy_q;
  assign timeout_o = timeout_q;

endmodule
